// File: rtl/popcnt_window_accum.sv
// Windowed accumulator for upstream popcount samples: sum, max, min and a sticky threshold alarm per window.
// Build option: define POPCNT_WIN_MINMAX_EN to keep running max/min; otherwise max_o/min_o are tied to 0.
module popcnt_window_accum #(
   parameter int CNT_W   = 5,
   parameter int WIN_LEN = 16
) (
   input  logic                                clk_i,
   input  logic                                arst_n_i,
   input  logic                                clear_i,
   input  logic [CNT_W-1:0]                    cnt_i,
   input  logic                                cnt_val_i,
   input  logic [CNT_W+$clog2(WIN_LEN)-1:0]    thresh_i,
   output logic [CNT_W+$clog2(WIN_LEN)-1:0]    sum_o,
   output logic [CNT_W-1:0]                    max_o,
   output logic [CNT_W-1:0]                    min_o,
   output logic                                win_val_o,
   output logic [$clog2(WIN_LEN):0]            fill_o,
   output logic                                alarm_o,
   output logic [0:0]                          dbg_state_o
);

   localparam int SUM_W  = CNT_W + $clog2(WIN_LEN);
   localparam int FILL_W = $clog2(WIN_LEN) + 1;

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_ACCUM = 1'b1;

   localparam logic [FILL_W-1:0] LAST_FILL = FILL_W'(WIN_LEN - 1);

   // Input is valid-only: a sample is consumed on every edge where cnt_val_i
   // is high and clear_i is low; there is no ready and no backpressure.
   logic [0:0]        state_q, state_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [SUM_W-1:0]  acc_q, acc_d;
   logic [SUM_W-1:0]  sum_q, sum_d;
   logic              win_val_q, win_val_d;
   logic              alarm_q, alarm_d;
   logic [SUM_W-1:0]  cnt_ext;
   logic [SUM_W-1:0]  acc_plus;

`ifdef POPCNT_WIN_MINMAX_EN
   logic [CNT_W-1:0]  rmax_q, rmax_d;
   logic [CNT_W-1:0]  rmin_q, rmin_d;
   logic [CNT_W-1:0]  max_q, max_d;
   logic [CNT_W-1:0]  min_q, min_d;
   logic [CNT_W-1:0]  new_max;
   logic [CNT_W-1:0]  new_min;
`endif

   always_comb begin
      cnt_ext   = SUM_W'(cnt_i);
      acc_plus  = acc_q + cnt_ext;
      state_d   = state_q;
      fill_d    = fill_q;
      acc_d     = acc_q;
      sum_d     = sum_q;
      win_val_d = 1'b0;
      alarm_d   = alarm_q;
`ifdef POPCNT_WIN_MINMAX_EN
      new_max   = (cnt_i > rmax_q) ? cnt_i : rmax_q;
      new_min   = (cnt_i < rmin_q) ? cnt_i : rmin_q;
      rmax_d    = rmax_q;
      rmin_d    = rmin_q;
      max_d     = max_q;
      min_d     = min_q;
`endif

      // Clear outranks a coincident sample, including a closing one.
      if (clear_i) begin
         state_d = ST_EMPTY;
         fill_d  = '0;
         alarm_d = 1'b0;
      end else if (cnt_val_i) begin
         if (state_q == ST_EMPTY) begin
            state_d = ST_ACCUM;
            fill_d  = FILL_W'(1);
            acc_d   = cnt_ext;
`ifdef POPCNT_WIN_MINMAX_EN
            rmax_d  = cnt_i;
            rmin_d  = cnt_i;
`endif
         end else if (fill_q == LAST_FILL) begin
            state_d   = ST_EMPTY;
            fill_d    = '0;
            sum_d     = acc_plus;
            win_val_d = 1'b1;
            if (acc_plus >= thresh_i) begin
               alarm_d = 1'b1;
            end
`ifdef POPCNT_WIN_MINMAX_EN
            max_d     = new_max;
            min_d     = new_min;
`endif
         end else begin
            fill_d = fill_q + FILL_W'(1);
            acc_d  = acc_plus;
`ifdef POPCNT_WIN_MINMAX_EN
            rmax_d = new_max;
            rmin_d = new_min;
`endif
         end
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_q   <= ST_EMPTY;
         fill_q    <= '0;
         acc_q     <= '0;
         sum_q     <= '0;
         win_val_q <= 1'b0;
         alarm_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         fill_q    <= fill_d;
         acc_q     <= acc_d;
         sum_q     <= sum_d;
         win_val_q <= win_val_d;
         alarm_q   <= alarm_d;
      end
   end

`ifdef POPCNT_WIN_MINMAX_EN
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         rmax_q <= '0;
         rmin_q <= '0;
         max_q  <= '0;
         min_q  <= '0;
      end else begin
         rmax_q <= rmax_d;
         rmin_q <= rmin_d;
         max_q  <= max_d;
         min_q  <= min_d;
      end
   end

   assign max_o = max_q;
   assign min_o = min_q;
`else
   assign max_o = '0;
   assign min_o = '0;
`endif

   assign sum_o       = sum_q;
   assign win_val_o   = win_val_q;
   assign fill_o      = fill_q;
   assign alarm_o     = alarm_q;
   assign dbg_state_o = state_q;

endmodule

// File: doc/popcnt_window_accum.md
POPCNT_WINDOW_ACCUM -- requirements
Module: popcnt_window_accum

Interface
REQ-001 SHALL have parameter CNT_W, default 5, width of the incoming popcount value (matches upstream counter output width).
REQ-002 SHALL have parameter WIN_LEN, default 16, number of samples per window; legal range 2..1024.
REQ-003 SHALL derive localparam SUM_W = CNT_W + $clog2(WIN_LEN) and FILL_W = $clog2(WIN_LEN) + 1.
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port arst_n_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port clear_i  input  1  synchronous soft clear; aborts the current window.
REQ-007 SHALL have port cnt_i  input  CNT_W  popcount sample from the upstream stage.
REQ-008 SHALL have port cnt_val_i  input  1  cnt_i valid; no backpressure, every valid sample is consumed.
REQ-009 SHALL have port thresh_i  input  SUM_W  alarm threshold, sampled on the window-closing cycle.
REQ-010 SHALL have port sum_o  output  SUM_W  sum of the last completed window.
REQ-011 SHALL have port max_o  output  CNT_W  largest sample of the last completed window.
REQ-012 SHALL have port min_o  output  CNT_W  smallest sample of the last completed window.
REQ-013 SHALL have port win_val_o  output  1  one-cycle pulse; sum_o/max_o/min_o updated.
REQ-014 SHALL have port fill_o  output  FILL_W  samples accepted in the currently open window.
REQ-015 SHALL have port alarm_o  output  1  sticky flag: some completed window had sum >= thresh_i.

Function
REQ-016 SHALL implement two states: EMPTY (fill 0) and ACCUM (fill 1..WIN_LEN-1).
REQ-017 EMPTY + cnt_val_i: accumulator loads cnt_i, running max/min load cnt_i, fill_o becomes 1, go to ACCUM.
REQ-018 ACCUM + cnt_val_i with fill_o < WIN_LEN-1: accumulator += cnt_i, max/min updated, fill_o increments.
REQ-019 ACCUM + cnt_val_i with fill_o = WIN_LEN-1 (closing sample): sum_o <= accumulator + cnt_i, max_o/min_o include cnt_i, win_val_o asserted on the next cycle, fill_o returns to 0, state to EMPTY.
REQ-020 Latency SHALL be exactly 1 cycle from the edge accepting the closing sample to win_val_o high.
REQ-021 Back-to-back windows SHALL have no bubble: a valid sample on the cycle after closing opens the next window.
REQ-022 cnt_val_i low SHALL hold all state; gaps of any length are permitted mid-window.
REQ-023 sum_o/max_o/min_o SHALL hold their value between win_val_o pulses.
REQ-024 SUM_W SHALL be sufficient that the sum never wraps (WIN_LEN * (2**CNT_W - 1) fits).
REQ-025 On closing, alarm_o SHALL set if (accumulator + cnt_i) >= thresh_i; it clears only on clear_i or reset.
REQ-026 clear_i SHALL discard the open window (fill_o 0, EMPTY), clear alarm_o, keep sum_o/max_o/min_o, suppress win_val_o.
REQ-027 clear_i and cnt_val_i on the same cycle: clear wins, that sample is dropped.
REQ-028 clear_i on a closing-sample cycle: window discarded, no win_val_o pulse next cycle.
REQ-029 cnt_i values above the upstream maximum SHALL be accepted as-is; no saturation.

Reset
REQ-030 arst_n_i low SHALL asynchronously force: EMPTY, fill_o 0, sum_o 0, max_o 0, min_o 0, win_val_o 0, alarm_o 0.
REQ-031 Deassertion SHALL be synchronised externally; first sample is accepted on the first edge with arst_n_i high.
REQ-032 Reset mid-window SHALL discard the partial window with no win_val_o pulse.

Configuration
REQ-033 Macro POPCNT_WIN_MINMAX_EN defined: running max/min registers and max_o/min_o behave per REQ-017..019.
REQ-034 Macro POPCNT_WIN_MINMAX_EN undefined: no max/min registers; max_o and min_o SHALL be tied to 0; all else unchanged.

Verification (CNT_W=5, WIN_LEN=4, macro defined unless stated)
REQ-035 Samples 3,7,1,5 back-to-back, thresh 20 -> win_val_o one cycle after 4th, sum_o=16, max_o=7, min_o=1, alarm_o=0.
REQ-036 Two windows back-to-back 31,31,31,31 then 0,0,0,0, thresh 100 -> sum_o=124 then 0; alarm_o=1 after first, stays 1.
REQ-037 Samples 2,_,_,4,_,6,8 with gaps -> fill_o 1,1,1,2,2,3,0; single pulse, sum_o=20, max_o=8, min_o=2.
REQ-038 Samples 5,5,5 then clear_i together with 4th sample -> no pulse, fill_o=0, alarm_o=0, sum_o holds previous.
REQ-039 arst_n_i low after 2 samples, then 4 samples 1,2,3,4 -> all outputs 0 during reset; next pulse sum_o=10.
REQ-040 Macro undefined, samples 9,2,4,6 -> sum_o=21, max_o=0, min_o=0.
